// File: rtl/median_pkg.sv
// Shared types and helpers for blocks that time-share one MEDIAN sorting unit.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        WAIT,
        GAP
    } state_t;

    localparam int unsigned WIN_LEN = 9;
    localparam int unsigned RR_MAX  = 16;

    // Next requester after 'last' (wrapping modulo n) whose request bit is set.
    // Returns 'last' unchanged when nothing is requested.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                           input logic [3:0]        last,
                                           input int unsigned       n);
        logic [3:0] pick;
        logic       found;
        logic [4:0] s;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX; i++) begin
            s = {1'b0, last} + 5'(i);
            if (s >= 5'(n))
                s = s - 5'(n);
            if (!found && (i <= n) && req[s[3:0]]) begin
                pick  = s[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick with a registered last-grant pointer.
module rr_arbiter
    import median_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic            any,
    output logic [IDW-1:0]  pick
);

    logic [IDW-1:0]    last;
    logic [RR_MAX-1:0] req_ext;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
        any                = |req;
        pick               = IDW'(rr_pick(req_ext, 4'(last), NREQ));
    end

    // Pointer starts at the top index so requester 0 wins first after reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            last <= IDW'(NREQ - 1);
        else if (take)
            last <= pick;
    end

endmodule

// File: rtl/median_arbiter.sv
// Time-shares one 9-sample MEDIAN unit between NREQ requesters (round-robin),
// streaming each captured window as one DSI burst and returning the tagged result.
module median_arbiter
    import median_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*9*W-1:0]     WIN,
    output logic [NREQ-1:0]         ACK,
    output logic [W-1:0]            MED_DI,
    output logic                    MED_DSI,
    input  logic [W-1:0]            MED_DO,
    input  logic                    MED_DSO,
    output logic [W-1:0]            RES,
    output logic                    RES_VLD,
    output logic [IDW-1:0]          RES_ID,
    output logic                    BUSY,
    output logic                    ERR
);

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [W-1:0]    win_a  [NREQ][WIN_LEN];
    logic [W-1:0]    samp_q [WIN_LEN];
    logic [W-1:0]    samp_d [WIN_LEN];
    logic [3:0]      k_q, k_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic [NREQ-1:0] ack_d;
    logic            dsi_d;
    logic [W-1:0]    di_d;
    logic [W-1:0]    res_d;
    logic            vld_d;
    logic [IDW-1:0]  id_d;
    logic            err_d;

    logic            any;
    logic            take;
    logic [IDW-1:0]  pick;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .CLK  (CLK),
        .nRST (nRST),
        .req  (REQ),
        .take (take),
        .any  (any),
        .pick (pick)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++)
            for (int unsigned k = 0; k < WIN_LEN; k++)
                win_a[i][k] = WIN[(i*WIN_LEN + k)*W +: W];
    end

    // Sample 0 goes out on the grant edge itself, so FEED holds samples 0..8
    // with k_q pointing at the sample currently on MED_DI.
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        k_d     = k_q;
        wd_d    = wd_q;
        ack_d   = '0;
        dsi_d   = 1'b0;
        di_d    = MED_DI;
        res_d   = RES;
        vld_d   = 1'b0;
        id_d    = RES_ID;
        err_d   = 1'b0;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any) begin
                    take        = 1'b1;
                    samp_d      = win_a[pick];
                    id_d        = pick;
                    ack_d[pick] = 1'b1;
                    dsi_d       = 1'b1;
                    di_d        = win_a[pick][0];
                    k_d         = '0;
                    state_d     = FEED;
                end
            end
            FEED: begin
                if (k_q < 4'(WIN_LEN - 1)) begin
                    dsi_d = 1'b1;
                    di_d  = samp_q[k_q + 4'd1];
                    k_d   = k_q + 4'd1;
                end else begin
                    k_d     = '0;
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (MED_DSO) begin
                    res_d   = MED_DO;
                    vld_d   = 1'b1;
                    state_d = GAP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < WIN_LEN; k++)
                samp_q[k] <= '0;
            k_q     <= '0;
            wd_q    <= '0;
            ACK     <= '0;
            MED_DSI <= 1'b0;
            MED_DI  <= '0;
            RES     <= '0;
            RES_VLD <= 1'b0;
            RES_ID  <= '0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            k_q     <= k_d;
            wd_q    <= wd_d;
            ACK     <= ack_d;
            MED_DSI <= dsi_d;
            MED_DI  <= di_d;
            RES     <= res_d;
            RES_VLD <= vld_d;
            RES_ID  <= id_d;
            ERR     <= err_d;
            BUSY    <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_median_arbiter.sv
// Bench for median_arbiter: behavioural median-unit stub plus a round-robin/median reference.
module tb_median_arbiter;

    localparam int unsigned W        = 8;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned TIMEOUT  = 64;
    localparam int unsigned IDW      = 2;
    localparam int          STUB_LAT = 2;

    logic                CLK = 1'b0;
    logic                nRST = 1'b1;
    logic [NREQ-1:0]     REQ = '0;
    logic [NREQ*9*W-1:0] WIN;
    logic [NREQ-1:0]     ACK;
    logic [W-1:0]        MED_DI;
    logic                MED_DSI;
    logic [W-1:0]        MED_DO;
    logic                MED_DSO;
    logic [W-1:0]        RES;
    logic                RES_VLD;
    logic [IDW-1:0]      RES_ID;
    logic                BUSY;
    logic                ERR;

    int total = 0;
    int bad   = 0;
    int model_last = NREQ - 1;

    logic [W-1:0] win_m [NREQ][9];

    always #5 CLK = ~CLK;

    median_arbiter #(
        .W       (W),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .IDW     (IDW)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .REQ     (REQ),
        .WIN     (WIN),
        .ACK     (ACK),
        .MED_DI  (MED_DI),
        .MED_DSI (MED_DSI),
        .MED_DO  (MED_DO),
        .MED_DSO (MED_DSO),
        .RES     (RES),
        .RES_VLD (RES_VLD),
        .RES_ID  (RES_ID),
        .BUSY    (BUSY),
        .ERR     (ERR)
    );

    always_comb begin
        WIN = '0;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 9; k++)
                WIN[(i*9 + k)*W +: W] = win_m[i][k];
    end

    function automatic logic [W-1:0] median9(input logic [W-1:0] a [9]);
        logic [W-1:0] v [9];
        logic [W-1:0] t;
        v = a;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    // Median unit stub: gathers 9 strobed samples, answers STUB_LAT cycles later.
    logic [W-1:0] sbuf [9];
    int           scnt, scd;
    bit           spend;
    bit           stub_dead = 1'b0;
    bit           force_dso = 1'b0;
    logic         dso_q;
    logic [W-1:0] do_q;

    assign MED_DSO = dso_q | force_dso;
    assign MED_DO  = do_q;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            scnt  <= 0;
            scd   <= 0;
            spend <= 1'b0;
            dso_q <= 1'b0;
            do_q  <= '0;
        end else begin
            dso_q <= 1'b0;
            if (MED_DSI) begin
                sbuf[scnt] <= MED_DI;
                if (scnt == 8) begin
                    scnt  <= 0;
                    spend <= !stub_dead;
                    scd   <= STUB_LAT;
                end else begin
                    scnt <= scnt + 1;
                end
            end
            if (spend) begin
                if (scd <= 1) begin
                    dso_q <= 1'b1;
                    do_q  <= median9(sbuf);
                    spend <= 1'b0;
                end else begin
                    scd <= scd - 1;
                end
            end
        end
    end

    function automatic int ref_pick(input logic [NREQ-1:0] r, input int last);
        for (int off = 1; off <= NREQ; off++)
            if (r[(last + off) % NREQ])
                return (last + off) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        model_last = NREQ - 1;
    endtask

    task automatic make_win(input int i, input int m);
        int           j;
        logic [W-1:0] t;
        for (int k = 0; k < 4; k++) win_m[i][k] = W'($urandom_range(0, m - 1));
        win_m[i][4] = W'(m);
        for (int k = 5; k < 9; k++) win_m[i][k] = W'($urandom_range(m + 1, 255));
        for (int k = 8; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = win_m[i][k]; win_m[i][k] = win_m[i][j]; win_m[i][j] = t;
        end
    endtask

    task automatic rand_win(input int i);
        for (int k = 0; k < 9; k++) win_m[i][k] = W'($urandom_range(0, 255));
    endtask

    // One complete job: grant, 9-sample burst, result or timeout, GAP.
    task automatic do_job(input bit keep, input bit exp_err, input bit frc);
        int           g, w;
        bit           got;
        logic [W-1:0] wv [9];
        g   = ref_pick(REQ, model_last);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (ACK != '0) got = 1'b1;
        end
        if (!got || g < 0) begin
            chk("ack_seen", 32'(got), 32'(g >= 0 ? 0 : 1));
            chk("ack_seen", 0, 1);
            return;
        end
        wv = win_m[g];
        chk("ack_onehot", 32'(ACK), 32'(1) << g);
        chk("grant_id", 32'(RES_ID), 32'(g));
        chk("busy_feed", 32'(BUSY), 1);
        model_last = g;
        if (!keep) REQ[g] = 1'b0;
        if (frc) force_dso = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            chk("dsi_burst", 32'(MED_DSI), 1);
            chk("di_sample", 32'(MED_DI), 32'(wv[k]));
            chk("no_vld_feed", 32'(RES_VLD), 0);
            if (k == 1) chk("ack_pulse", 32'(ACK), 0);
            if (frc && k == 8) force_dso = 1'b0;
        end
        step();
        chk("dsi_end", 32'(MED_DSI), 0);
        got = 1'b0;
        w   = 0;
        for (int c = 0; c < TIMEOUT + 10 && !got; c++) begin
            if (RES_VLD || ERR) got = 1'b1;
            else begin
                step();
                w++;
            end
        end
        if (!got) begin
            chk("result_seen", 0, 1);
            return;
        end
        if (exp_err) begin
            chk("err_latency", 32'(w), TIMEOUT);
            chk("err_no_vld", 32'(RES_VLD), 0);
        end else begin
            chk("res_latency", 32'(w), 32'(STUB_LAT + 1));
            chk("res_value", 32'(RES), 32'(median9(wv)));
            chk("res_id", 32'(RES_ID), 32'(g));
            chk("res_no_err", 32'(ERR), 0);
        end
        step();
        chk("vld_pulse", 32'(RES_VLD), 0);
        chk("err_pulse", 32'(ERR), 0);
        chk("busy_gap_end", 32'(BUSY), 0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) rand_win(i);

        // Reset values, observed with no clock edge yet.
        #1 nRST = 1'b0;
        #1;
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_dsi", 32'(MED_DSI), 0);
        chk("rst_di", 32'(MED_DI), 0);
        chk("rst_vld", 32'(RES_VLD), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_res", 32'(RES), 0);
        chk("rst_id", 32'(RES_ID), 0);
        step();
        nRST = 1'b1;

        // Directed window 9,1,8,2,7,3,6,4,5 -> median 5.
        win_m[0] = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        REQ = 4'b0001;
        do_job(1'b0, 1'b0, 1'b0);

        // All four requesting, each dropping on ACK: order 0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) make_win(i, 10 * (i + 1));
        REQ = 4'b1111;
        for (int j = 0; j < 4; j++) do_job(1'b0, 1'b0, 1'b0);

        // Requesters 0 and 2 keep requesting: 0,2,0,2.
        do_reset();
        for (int i = 0; i < NREQ; i++) rand_win(i);
        REQ = 4'b0101;
        for (int j = 0; j < 4; j++) do_job(1'b1, 1'b0, 1'b0);
        REQ = '0;

        // Silent median unit: watchdog, then pending requester 1 served.
        do_reset();
        stub_dead = 1'b1;
        REQ = 4'b0011;
        do_job(1'b0, 1'b1, 1'b0);
        stub_dead = 1'b0;
        do_job(1'b0, 1'b0, 1'b0);

        // DSO held high through the burst is ignored.
        do_reset();
        rand_win(2);
        REQ = 4'b0100;
        do_job(1'b0, 1'b0, 1'b1);

        // Reset during FEED sample 4 takes effect without a clock edge.
        do_reset();
        rand_win(0);
        REQ = 4'b0001;
        begin
            bit got;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                step();
                if (ACK != '0) got = 1'b1;
            end
            chk("mid_ack_seen", 32'(got), 1);
        end
        REQ = '0;
        repeat (4) step();
        chk("mid_di4", 32'(MED_DI), 32'(win_m[0][4]));
        chk("mid_dsi4", 32'(MED_DSI), 1);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_dsi", 32'(MED_DSI), 0);
        chk("mid_rst_ack", 32'(ACK), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        REQ = 4'b1010;
        model_last = NREQ - 1;
        #1 nRST = 1'b1;
        do_job(1'b0, 1'b0, 1'b0);
        do_job(1'b0, 1'b0, 1'b0);

        // Random request patterns and windows.
        do_reset();
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < NREQ; i++) rand_win(i);
            REQ = REQ | NREQ'($urandom_range(0, 15));
            if (REQ == '0) REQ = NREQ'($urandom_range(1, 15));
            do_job(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        REQ = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
